xilinx_mailbox_read_adaptor: RTL
================================

Name: xilinx_mailbox_read_adaptor

Overview:
AXI4-to-AXI4-Lite read-channel adaptor for the Xilinx mailbox; the read-side counterpart of the mailbox write adaptor. It accepts AXI4 ar bursts, splits them into single-word AXI4-Lite reads on one of two mailbox ports (selected by address bit 12), and returns R beats with reflected ID, RLast and 32-to-AXI_DATA_WIDTH data replication. It sits between the host-side AXI interconnect and the two mailbox slave ports.

Parameters:
AXI_ADDR_WIDTH, 32, address width of all interfaces
AXI_DATA_WIDTH, 64, AXI4 data width; 32 or 64 only
AXI_ID_WIDTH, 10, AXI4 ID width
AXI_USER_WIDTH, 6, AXI4 R user width

Ports:
Clk_CI  in  1  clock
Rst_RBI  in  1  asynchronous active-low reset
ArAddr_DI  in  AXI_ADDR_WIDTH  AXI4 read address
ArValid_SI  in  1  ar valid
ArReady_SO  out  1  ar ready
ArLen_SI  in  8  burst length minus 1
ArId_DI  in  AXI_ID_WIDTH  read ID
RData_DO  out  AXI_DATA_WIDTH  read data
RValid_SO  out  1  r valid
RReady_SI  in  1  r ready
RId_DO  out  AXI_ID_WIDTH  reflected ID
RResp_DO  out  2  response from selected port
RLast_SO  out  1  last beat of burst
RUser_DO  out  AXI_USER_WIDTH  constant 0
If0_ArAddr_DO  out  AXI_ADDR_WIDTH  port 0 read address
If0_ArValid_SO  out  1  port 0 ar valid
If0_ArReady_SI  in  1  port 0 ar ready
If0_RData_DI  in  32  port 0 read data
If0_RValid_SI  in  1  port 0 r valid
If0_RReady_SO  out  1  port 0 r ready
If0_RResp_DI  in  2  port 0 response
If1_* (ArAddr_DO, ArValid_SO, ArReady_SI, RData_DI, RValid_SI, RReady_SO, RResp_DI)  same widths/directions as If0_*, port 1

Behaviour:
- Reset (Rst_RBI low, async): state IDLE; stored ID, address, select, beat counter = 0. All valid/ready outputs 0 except ArReady_SO = 1 (IDLE); RData_DO/RId_DO/RResp_DO/RUser_DO = 0; RLast_SO = 0.
- Port select: Sel = ArAddr_DI[12], captured at ar handshake; 0x0000-0x0FFF -> If0, 0x1000-0x1FFF -> If1. Unselected port's valid/ready outputs held 0 and its ArAddr output 0.
- FSM states IDLE, ADDR, DATA:
  - IDLE: ArReady_SO = 1. On ArValid_SI: store ArAddr, ArId, Sel, BeatCnt = ArLen_SI -> ADDR. No downstream activity.
  - ADDR: IfSel_ArValid_SO = 1, IfSel_ArAddr_DO = stored address. On IfSel_ArReady_SI -> DATA. ArReady_SO = 0.
  - DATA: pass-through: RValid_SO = IfSel_RValid_SI, IfSel_RReady_SO = RReady_SI. RResp_DO = IfSel_RResp_DI. RLast_SO = (BeatCnt == 0). On a handshake (valid & ready): if BeatCnt == 0 -> IDLE; else BeatCnt -= 1, address += AXI_DATA_WIDTH/8 with bits [log2(AXI_DATA_WIDTH/8)-1:0] cleared, -> ADDR.
- Exactly one downstream read per beat, so destructive mailbox FIFO reads are never issued speculatively.
- Data width: AXI_DATA_WIDTH 64 -> RData_DO = {d, d} (32-bit word replicated in both lanes); 32 -> RData_DO = d. RData_DO = 0 outside DATA.
- RId_DO = stored ID in DATA, else 0. RUser_DO always 0.
- Latency: ar handshake at cycle N -> downstream ArValid at N+1; R forwarded combinationally in the cycle downstream RValid is seen.
- New ar is not accepted until the final R handshake of the current burst (one outstanding transaction).
- SLVERR/DECERR from a port is forwarded per beat; burst continues to completion.
- Reset mid-burst: returns to IDLE immediately; no further beats or RLast emitted.
- Illegal state encodings -> IDLE.

Test Plan:
- Single read, port 0: ar addr 0x0000_0004, len 0, id 0x155; If0 returns 0xDEADBEEF OKAY -> one R beat: RData 0xDEADBEEF_DEADBEEF, RId 0x155, RLast 1, RResp 00; If0_ArAddr 0x0000_0004.
- Port 1 select: ar addr 0x0000_1008 -> only If1_ArValid asserted, If1_ArAddr 0x1008; If0 valids stay 0.
- Burst len 2 at 0x0000_0004 -> three downstream reads at 0x0004, 0x0008, 0x0010; RLast only on third beat.
- Backpressure: RReady_SI low 5 cycles while If0_RValid high -> If0_RReady low, RValid held, no extra downstream ar; completes after RReady rises.
- ArReady_SO held 0 during a burst; second ar is accepted only in the cycle after the final R handshake. Error: If1 returns RResp 10 -> RResp_DO 10.
- Async reset asserted in DATA -> all valids 0, ArReady_SO 1 after release, next burst behaves normally.

Source files
------------

// File: rtl/xilinx_mailbox_read_adaptor.sv
// AXI4 read-burst to AXI4-Lite single-read adaptor for the two mailbox ports.
// One downstream read is issued per beat, so destructive FIFO reads are never speculative.
module xilinx_mailbox_read_adaptor #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 10,
    parameter int AXI_USER_WIDTH = 6
) (
    input  logic                      Clk_CI,
    input  logic                      Rst_RBI,
    input  logic [AXI_ADDR_WIDTH-1:0] ArAddr_DI,
    input  logic                      ArValid_SI,
    output logic                      ArReady_SO,
    input  logic [7:0]                ArLen_SI,
    input  logic [AXI_ID_WIDTH-1:0]   ArId_DI,
    output logic [AXI_DATA_WIDTH-1:0] RData_DO,
    output logic                      RValid_SO,
    input  logic                      RReady_SI,
    output logic [AXI_ID_WIDTH-1:0]   RId_DO,
    output logic [1:0]                RResp_DO,
    output logic                      RLast_SO,
    output logic [AXI_USER_WIDTH-1:0] RUser_DO,
    output logic [AXI_ADDR_WIDTH-1:0] If0_ArAddr_DO,
    output logic                      If0_ArValid_SO,
    input  logic                      If0_ArReady_SI,
    input  logic [31:0]               If0_RData_DI,
    input  logic                      If0_RValid_SI,
    output logic                      If0_RReady_SO,
    input  logic [1:0]                If0_RResp_DI,
    output logic [AXI_ADDR_WIDTH-1:0] If1_ArAddr_DO,
    output logic                      If1_ArValid_SO,
    input  logic                      If1_ArReady_SI,
    input  logic [31:0]               If1_RData_DI,
    input  logic                      If1_RValid_SI,
    output logic                      If1_RReady_SO,
    input  logic [1:0]                If1_RResp_DI
);

    localparam int BYTES = AXI_DATA_WIDTH / 8;
    localparam logic [AXI_ADDR_WIDTH-1:0] OFF_MASK = AXI_ADDR_WIDTH'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
    logic                      sel_q, sel_d;
    logic [7:0]                beat_cnt_q, beat_cnt_d;

    logic        sel_ar_ready;
    logic        sel_r_valid;
    logic [31:0] sel_r_data;
    logic [1:0]  sel_r_resp;

    assign sel_ar_ready = sel_q ? If1_ArReady_SI : If0_ArReady_SI;
    assign sel_r_valid  = sel_q ? If1_RValid_SI  : If0_RValid_SI;
    assign sel_r_data   = sel_q ? If1_RData_DI   : If0_RData_DI;
    assign sel_r_resp   = sel_q ? If1_RResp_DI   : If0_RResp_DI;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        id_d       = id_q;
        sel_d      = sel_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (ArValid_SI) begin
                    addr_d     = ArAddr_DI;
                    id_d       = ArId_DI;
                    sel_d      = ArAddr_DI[12];
                    beat_cnt_d = ArLen_SI;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                if (sel_ar_ready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (sel_r_valid && RReady_SI) begin
                    if (beat_cnt_q == 8'd0) begin
                        state_d = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 8'd1;
                        // Next beat starts on the following bus-word boundary.
                        addr_d     = (addr_q + AXI_ADDR_WIDTH'(BYTES)) & ~OFF_MASK;
                        state_d    = ADDR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            id_q       <= '0;
            sel_q      <= 1'b0;
            beat_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            id_q       <= id_d;
            sel_q      <= sel_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        ArReady_SO     = (state_q == IDLE);
        RValid_SO      = 1'b0;
        RData_DO       = '0;
        RId_DO         = '0;
        RResp_DO       = 2'b00;
        RLast_SO       = 1'b0;
        If0_ArAddr_DO  = '0;
        If0_ArValid_SO = 1'b0;
        If0_RReady_SO  = 1'b0;
        If1_ArAddr_DO  = '0;
        If1_ArValid_SO = 1'b0;
        If1_RReady_SO  = 1'b0;
        if (state_q == ADDR) begin
            if (sel_q) begin
                If1_ArValid_SO = 1'b1;
                If1_ArAddr_DO  = addr_q;
            end else begin
                If0_ArValid_SO = 1'b1;
                If0_ArAddr_DO  = addr_q;
            end
        end else if (state_q == DATA) begin
            if (sel_q) begin
                If1_RReady_SO = RReady_SI;
            end else begin
                If0_RReady_SO = RReady_SI;
            end
            RValid_SO = sel_r_valid;
            // The 32-bit mailbox word is mirrored into every lane of the AXI4 bus.
            RData_DO  = {(AXI_DATA_WIDTH / 32){sel_r_data}};
            RId_DO    = id_q;
            RResp_DO  = sel_r_resp;
            RLast_SO  = (beat_cnt_q == 8'd0);
        end
    end

    assign RUser_DO = '0;

endmodule
